buzzer_beep_seq: RTL
====================

// Module: buzzer_beep_seq
// PURPOSE
//   Downstream consumer of the fixed 1600 Hz square-wave tone generator.
//   Gates the incoming tone into a burst of N beeps (ON_CYC on / OFF_CYC gap)
//   on a start pulse and drives the passive buzzer pin.
//   Reports busy/done to the table control logic. Single clock domain (50 MHz).
// PARAMETERS
//   ON_CYC   5_000_000  clk cycles per beep (100 ms @ 50 MHz); must be >= 1
//   OFF_CYC  5_000_000  clk cycles of silence between beeps; must be >= 1
//   CNT_W    24         phase counter width; must hold max(ON_CYC,OFF_CYC)-1
// PORTS
//   clk         in   1  50 MHz system clock
//   rst         in   1  synchronous reset, active high
//   tone_in     in   1  1600 Hz square wave from tone generator (same clk domain)
//   start       in   1  request burst; sampled on each rising clk edge
//   beep_num    in   4  beeps per burst (1..15); latched on accepted start
//   stop        in   1  synchronous abort; silences output, returns to IDLE
//   busy        out  1  high while a burst is in progress
//   done        out  1  one-cycle pulse after last beep of a completed burst
//   buzzer_out  out  1  gated tone to buzzer pin
// BEHAVIOUR
//   - Reset: state=IDLE, counters=0, busy=0, done=0, buzzer_out=0. Clears any
//     burst in progress; no done pulse issued.
//   - States: IDLE, ON, GAP. All outputs registered.
//   - IDLE: start=1 and beep_num!=0 at edge k -> latch beep_num into remaining,
//     state=ON, phase counter=0, busy=1 after edge k.
//     start with beep_num==0 is ignored (stays IDLE, no done).
//   - ON: state holds for exactly ON_CYC cycles. At the end: decrement
//     remaining. If result is 0 -> IDLE, busy=0, done=1 for one cycle
//     (no trailing gap). Otherwise -> GAP, phase counter=0.
//   - GAP: state holds for exactly OFF_CYC cycles, then -> ON, phase counter=0.
//   - Burst length in cycles: N*ON_CYC + (N-1)*OFF_CYC, from the first ON cycle
//     to the cycle done is asserted.
//   - buzzer_out <= tone_in & (state==ON). Output lags state and tone_in by
//     one cycle. No glitches: tone_in is a registered same-domain signal.
//   - start while busy: ignored. beep_num changes while busy: ignored.
//   - stop=1 (any state): next edge -> IDLE, busy=0, buzzer_out=0, no done.
//     stop has priority over start in the same cycle.
//   - done and start in the same cycle (IDLE re-entry): a new start is accepted
//     only on a cycle where the registered state is IDLE. The earliest restart
//     is the cycle done is high.
//   - Phase counter wraps only by explicit clear. Never free-runs past ON_CYC-1
//     or OFF_CYC-1.
// TESTING  (ON_CYC=10, OFF_CYC=5, tone_in toggling every 2 clk)
//   - rst high 3 cycles mid-burst -> busy=0, buzzer_out=0 next cycle; no done
//     pulse at any later point.
//   - start, beep_num=3 -> buzzer_out follows tone_in (1 cycle late) for 10
//     cycles, then 0 for 5 cycles, repeated; done pulse 40 cycles after the
//     first ON cycle; busy high for exactly 40 cycles.
//   - start, beep_num=0 -> busy stays 0, buzzer_out stays 0, no done pulse.
//   - start, beep_num=2, then start, beep_num=5 pulsed during the first GAP
//     -> exactly 2 beeps, done after 25 cycles.
//   - stop asserted on 4th ON cycle of beep 2 -> buzzer_out=0 and busy=0 next
//     cycle; no done pulse. A subsequent start is accepted normally.
//   - start asserted on the done cycle, beep_num=1 -> second burst begins the
//     next cycle; 10 ON cycles then done again.

Source files
------------

// File: rtl/buzzer_beep_seq.sv
// buzzer_beep_seq: gates a same-domain tone into a burst of N beeps.
// A start pulse latches the beep count and runs ON_CYC cycles of tone,
// then OFF_CYC cycles of silence, repeated. There is no gap after the
// last beep. stop aborts the burst at any time without a done pulse.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active high
//   tone_in     square-wave tone (registered, same clock domain)
//   start       burst request, honoured only while the FSM is idle
//   beep_num    beeps per burst (1..15); zero requests are dropped
//   stop        synchronous abort; takes priority over start
//   busy        high while a burst is running
//   done        one-cycle pulse after the last beep of a completed burst
//   buzzer_out  gated tone to the buzzer pin
module buzzer_beep_seq #(
  parameter int unsigned ON_CYC  = 5_000_000,
  parameter int unsigned OFF_CYC = 5_000_000,
  parameter int unsigned CNT_W   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tone_in,
  input  logic       start,
  input  logic [3:0] beep_num,
  input  logic       stop,
  output logic       busy,
  output logic       done,
  output logic       buzzer_out
);

  localparam int unsigned NUM_W = 4;
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [NUM_W-1:0]   remaining_q, remaining_d;
  logic               busy_d, done_d, buzz_d;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      remaining_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      buzzer_out  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      busy        <= busy_d;
      done        <= done_d;
      buzzer_out  <= buzz_d;
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;

    if (stop) begin
      state_d     = S_IDLE;
      phase_d     = '0;
      remaining_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          phase_d = '0;
          if (start && (beep_num != '0)) begin
            remaining_d = beep_num;
            state_d     = S_ON;
          end
        end

        S_ON: begin
          if (phase_q == ON_LAST) begin
            phase_d     = '0;
            remaining_d = remaining_q - NUM_W'(1);
            // Last beep ends the burst directly; no trailing gap.
            if (remaining_q == NUM_W'(1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            phase_d = phase_q + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (phase_q == OFF_LAST) begin
            phase_d = '0;
            state_d = S_ON;
          end else begin
            phase_d = phase_q + CNT_W'(1);
          end
        end

        default: begin
          state_d     = S_IDLE;
          phase_d     = '0;
          remaining_d = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
    // Tone follows the current state one cycle late; stop silences it at once.
    buzz_d = tone_in & (state_q == S_ON) & ~stop;
  end

endmodule
